if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC SHALL default 32'h0000_0000 and be the PC loaded on reset.
REQ-002 Parameter TIMEOUT SHALL default 16 and be the maximum number of WAIT cycles allowed before a fetch error.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  instruction-memory read request strobe.
REQ-006 imem_addr  output  32  read address; equals pc.
REQ-007 imem_rvalid  input  1  read data valid.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 stall  input  1  downstream not ready; holds current instruction.
REQ-010 branch  input  1  Branch from control unit.
REQ-011 zero  input  1  ALU zero flag.
REQ-012 instr_valid  output  1  decoded fields below are valid.
REQ-013 op_code  output  6  IR[31:26], fed to control op_code.
REQ-014 funct_field  output  6  IR[5:0], fed to control funct_field.
REQ-015 rs, rt, rd, shamt  output  5 each  IR[25:21], IR[20:16], IR[15:11], IR[10:6].
REQ-016 imm  output  16  IR[15:0].
REQ-017 pc  output  32  address of instruction in IR.
REQ-018 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, VALID, ERROR.
REQ-020 IDLE: outputs inactive; unconditionally -> REQ next cycle.
REQ-021 REQ: imem_req=1 for exactly one cycle, imem_addr=pc; -> WAIT; timeout counter cleared.
REQ-022 WAIT: imem_req=0; on imem_rvalid=1, IR<=imem_rdata, -> VALID; else counter increments.
REQ-023 WAIT with counter==TIMEOUT-1 and imem_rvalid=0 -> ERROR; fetch_err=1.
REQ-024 imem_rvalid outside WAIT SHALL be ignored (IR unchanged).
REQ-025 VALID: instr_valid=1; IR and pc held stable while stall=1.
REQ-026 VALID with stall=0: branch and zero sampled that cycle; pc <= next PC; -> REQ; instr_valid=0 from next cycle.
REQ-027 Next PC = pc+4 unless branch&zero, then pc+4+(sign-extended imm <<2).
REQ-028 PC arithmetic SHALL be modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000; negative offsets wrap likewise).
REQ-029 branch, zero SHALL be ignored in all states except VALID with stall=0.
REQ-030 ERROR: terminal until rst; imem_req=0, instr_valid=0, fetch_err=1.
REQ-031 Minimum latency REQ-cycle to instr_valid SHALL be 2 cycles (rvalid in first WAIT cycle).
REQ-032 Field outputs SHALL be pure slices of IR (no extra delay).

Reset
REQ-033 rst=1 SHALL, at the next edge, force state IDLE, pc=RESET_PC, IR=0, counter=0, fetch_err=0, regardless of state (including mid-WAIT, VALID, ERROR).
REQ-034 During and the cycle after reset: imem_req=0, instr_valid=0, all field outputs 0.
REQ-035 A late imem_rvalid arriving after reset for a pre-reset request SHALL be ignored (state is IDLE/REQ, per REQ-024).

Structure
REQ-036 Shared package mips_pkg SHALL hold the fetch state enum, opcode constants (R-format 000000, LW 100011, SW 101011, BEQ 000100) and funct constants (ADD 100000, SUB 100010).
REQ-037 Next-PC computation SHALL be one combinational sub-module, pc_next (inputs pc, imm, take; output next pc).

Verification
REQ-038 Reset, rvalid one cycle after req with rdata 32'h0000_0020 -> imem_addr 0x0, instr_valid 2 cycles after req, op_code 000000, funct_field 100000.
REQ-039 Stall=1 for 3 cycles in VALID with rdata 32'h8C22_0004 -> op_code 100011, rt 2, imm 0x0004 stable 3 cycles, no imem_req.
REQ-040 pc 0x10, rdata 32'h1021_FFFE, branch=1 zero=1 on release -> next imem_addr 0x0C; same with zero=0 -> 0x14.
REQ-041 imem_rvalid withheld 16 WAIT cycles -> fetch_err=1, state ERROR; rst -> fetch_err=0, imem_addr=RESET_PC.
REQ-042 RESET_PC=32'hFFFF_FFFC, no branch -> second fetch at 0x0000_0000.
REQ-043 rst asserted mid-WAIT, then rvalid during IDLE -> IR stays 0, instr_valid=0, fresh req at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, opcode and funct encodings.
// Pure declarations; no timing or flow-control behaviour of its own.
package mips_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      VALID = 3'd3,
      ERROR = 3'd4
   } fetch_state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;

endpackage

// File: rtl/pc_next.sv
// Next-PC adder: pc+4, plus the sign-extended word offset when the branch is taken.
// Latency: combinational; no backpressure.
module pc_next
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm,
   input  logic        take,
   output logic [31:0] next_pc
);

   logic [31:0] offset;

   // Wraps modulo 2^32 naturally, including negative offsets.
   assign offset  = take ? {{14{imm[15]}}, imm, 2'b00} : 32'h0000_0000;
   assign next_pc = pc + 32'd4 + offset;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one request per instruction, IR captured on rvalid in WAIT, fields sliced from IR.
// Latency: REQ to instr_valid is 2 cycles minimum; stall holds IR/pc in VALID; memory timeout is terminal until rst.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   output logic        instr_valid,
   output logic [5:0]  op_code,
   output logic [5:0]  funct_field,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm,
   output logic [31:0] pc,
   output logic        fetch_err
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ir_q, ir_d;
   logic [15:0]  cnt_q, cnt_d;
   logic         err_q, err_d;
   logic         take;
   logic [31:0]  pc_nxt;

   // Branch inputs only matter on the cycle an instruction is released.
   assign take = branch & zero & (state_q == VALID) & ~stall;

   pc_next u_pc_next (
      .pc      (pc_q),
      .imm     (ir_q[15:0]),
      .take    (take),
      .next_pc (pc_nxt)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            cnt_d   = 16'd0;
            state_d = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               ir_d    = imem_rdata;
               state_d = VALID;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         VALID: begin
            if (!stall) begin
               pc_d    = pc_nxt;
               state_d = REQ;
            end
         end
         ERROR: err_d = 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= 32'h0000_0000;
         cnt_q   <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Strobes are masked while rst is high so nothing escapes before the reset edge.
   assign imem_req    = (state_q == REQ) & ~rst;
   assign instr_valid = (state_q == VALID) & ~rst;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign fetch_err   = err_q;

   assign op_code     = ir_q[31:26];
   assign rs          = ir_q[25:21];
   assign rt          = ir_q[20:16];
   assign rd          = ir_q[15:11];
   assign shamt       = ir_q[10:6];
   assign funct_field = ir_q[5:0];
   assign imm         = ir_q[15:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch timing, stall hold, branch target, timeout, reset recovery, PC wrap.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall, branch, zero;

   logic        imem_req, instr_valid, fetch_err;
   logic [31:0] imem_addr, pc;
   logic [5:0]  op_code, funct_field;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;

   logic        w_imem_req, w_instr_valid, w_fetch_err;
   logic [31:0] w_imem_addr, w_pc;
   logic [5:0]  w_op_code, w_funct_field;
   logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
   logic [15:0] w_imm;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   if_stage dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
      .branch(branch), .zero(zero), .instr_valid(instr_valid), .op_code(op_code),
      .funct_field(funct_field), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .imm(imm), .pc(pc), .fetch_err(fetch_err)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
      .branch(branch), .zero(zero), .instr_valid(w_instr_valid), .op_code(w_op_code),
      .funct_field(w_funct_field), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt),
      .imm(w_imm), .pc(w_pc), .fetch_err(w_fetch_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (imem_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // From the REQ cycle: answer in the first WAIT cycle, end up in VALID.
   task automatic deliver(input logic [31:0] data);
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      tick();
      imem_rvalid = 1'b0;
   endtask

   task automatic release_instr(input logic b, input logic z);
      branch = b;
      zero   = z;
      stall  = 1'b0;
      tick();
      branch = 1'b0;
      zero   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_strobes: req=%b valid=%b want 0 0", imem_req, instr_valid);
      end
      rst = 1'b0;
      vectors++;
      if (imem_addr !== 32'h0 || pc !== 32'h0 || fetch_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: addr=%h pc=%h err=%b want 0 0 0", imem_addr, pc, fetch_err);
      end
      vectors++;
      if ({op_code, funct_field, rs, rt, rd, shamt, imm} !== 48'h0 || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_fields: op=%h fn=%h imm=%h req=%b want all 0", op_code, funct_field, imm, imem_req);
      end
   endtask

   task automatic test_first_fetch();
      bit ok;
      wait_req(ok);
      vectors++;
      if (!ok || imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL first_req: seen=%0d addr=%h want 1 00000000", ok, imem_addr);
      end
      tick();
      vectors++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL wait_strobes: req=%b valid=%b want 0 0", imem_req, instr_valid);
      end
      branch = 1'b1;
      zero = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata = 32'h0000_0020;
      tick();
      imem_rvalid = 1'b0;
      branch = 1'b0;
      zero = 1'b0;
      vectors++;
      if (instr_valid !== 1'b1 || op_code !== 6'b000000 || funct_field !== 6'b100000 || pc !== 32'h0) begin
         miscompares++;
         $display("FAIL first_valid: valid=%b op=%b fn=%b pc=%h want 1 000000 100000 0", instr_valid, op_code, funct_field, pc);
      end
      release_instr(1'b0, 1'b0);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL seq_next: req=%b addr=%h valid=%b want 1 00000004 0", imem_req, imem_addr, instr_valid);
      end
   endtask

   task automatic test_stall();
      deliver(32'h8C22_0004);
      stall = 1'b1;
      branch = 1'b1;
      zero = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (instr_valid !== 1'b1 || imem_req !== 1'b0 || op_code !== 6'b100011 || rt !== 5'd2 || imm !== 16'h0004 || pc !== 32'h4) begin
            miscompares++;
            $display("FAIL stall_hold%0d: valid=%b req=%b op=%b rt=%0d imm=%h pc=%h want 1 0 100011 2 0004 4", i, instr_valid, imem_req, op_code, rt, imm, pc);
         end
      end
      release_instr(1'b0, 1'b0);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         miscompares++;
         $display("FAIL stall_release: req=%b addr=%h want 1 00000008", imem_req, imem_addr);
      end
   endtask

   task automatic test_branch();
      deliver(32'h0);
      release_instr(1'b0, 1'b0);
      deliver(32'h0);
      release_instr(1'b0, 1'b0);
      deliver(32'h1021_FFFE);
      vectors++;
      if (pc !== 32'h10 || op_code !== 6'b000100 || rs !== 5'd1 || rt !== 5'd1 || imm !== 16'hFFFE) begin
         miscompares++;
         $display("FAIL beq_fields: pc=%h op=%b rs=%0d rt=%0d imm=%h want 10 000100 1 1 fffe", pc, op_code, rs, rt, imm);
      end
      release_instr(1'b1, 1'b1);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0C) begin
         miscompares++;
         $display("FAIL branch_taken: req=%b addr=%h want 1 0000000c", imem_req, imem_addr);
      end
      deliver(32'h0);
      release_instr(1'b0, 1'b0);
      deliver(32'h1021_FFFE);
      release_instr(1'b1, 1'b0);
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
         miscompares++;
         $display("FAIL branch_not_taken: req=%b addr=%h want 1 00000014", imem_req, imem_addr);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      tick();
      for (int i = 0; i < 15; i++) tick();
      vectors++;
      if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_early: err=%b req=%b after 16 wait cycles want 0 0", fetch_err, imem_req);
      end
      tick();
      vectors++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_err: err=%b req=%b valid=%b want 1 0 0", fetch_err, imem_req, instr_valid);
      end
      imem_rvalid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) tick();
      imem_rvalid = 1'b0;
      vectors++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || op_code !== 6'b000100) begin
         miscompares++;
         $display("FAIL error_sticky: err=%b req=%b valid=%b op=%b want 1 0 0 000100", fetch_err, imem_req, instr_valid, op_code);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (fetch_err !== 1'b0 || imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL error_reset: err=%b addr=%h want 0 00000000", fetch_err, imem_addr);
      end
      wait_req(ok);
      vectors++;
      if (!ok || imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL error_refetch: seen=%0d addr=%h want 1 00000000", ok, imem_addr);
      end
   endtask

   task automatic test_reset_mid_wait();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      tick();
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || op_code !== 6'h0 || imm !== 16'h0) begin
         miscompares++;
         $display("FAIL late_rvalid: req=%b addr=%h valid=%b op=%h imm=%h want 1 0 0 0 0", imem_req, imem_addr, instr_valid, op_code, imm);
      end
      tick();
      imem_rvalid = 1'b0;
      vectors++;
      if (instr_valid !== 1'b0 || op_code !== 6'h0) begin
         miscompares++;
         $display("FAIL rvalid_in_req: valid=%b op=%h want 0 0", instr_valid, op_code);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_req(ok);
      vectors++;
      if (!ok || w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin
         miscompares++;
         $display("FAIL wrap_first: seen=%0d req=%b addr=%h want 1 1 fffffffc", ok, w_imem_req, w_imem_addr);
      end
      deliver(32'h0);
      release_instr(1'b0, 1'b0);
      vectors++;
      if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL wrap_second: req=%b addr=%h want 1 00000000", w_imem_req, w_imem_addr);
      end
   endtask

   initial begin
      rst = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
      stall = 1'b0;
      branch = 1'b0;
      zero = 1'b0;
      test_reset();
      test_first_fetch();
      test_stall();
      test_branch();
      test_timeout();
      test_reset_mid_wait();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
